cpu_run_ctrl: RTL and testbench

Run/dump sequencer for the pipelined MIPS CPU.
- Launches a program: clears PC, then enables the pipeline.
- Counts execution cycles and detects program completion from the MEM/WB finish flag.
- Drains the pipeline, then streams the whole data memory out over a valid/ready port.
- Provides a cycle-count watchdog that aborts runaway programs.

---
 rtl/cpu_run_ctrl.sv | 137 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/dump sequencer for the pipelined MIPS CPU: launches a program, watches
// for completion or runaway, drains the pipeline and streams data memory out.
module cpu_run_ctrl #(
    parameter int MEM_WORDS      = 512,
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 300,
    parameter int DRAIN_CYCLES   = 4,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpu_finish,
    output logic              cpu_pc_clear,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done,
    output logic              timeout
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0]     DRN_LOAD  = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_RD,
        S_LAT,
        S_PRES,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state;
    logic          fin_q;
    logic          fin_edge;
    logic [DW-1:0] drain_cnt;

    // fin_q tracks the level every cycle so a flag still high from the
    // previous run cannot look like a fresh completion.
    assign fin_edge = cpu_finish & ~fin_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            fin_q        <= 1'b0;
            drain_cnt    <= '0;
            cpu_pc_clear <= 1'b0;
            cpu_run      <= 1'b0;
            mem_rd_addr  <= '0;
            dump_valid   <= 1'b0;
            dump_addr    <= '0;
            dump_data    <= '0;
            cycle_count  <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            fin_q <= cpu_finish;
            unique case (state)
                S_IDLE, S_DONE, S_ABORT: begin
                    if (start) begin
                        state        <= S_INIT;
                        cpu_pc_clear <= 1'b1;
                        cycle_count  <= '0;
                        done         <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                S_INIT: begin
                    cpu_pc_clear <= 1'b0;
                    cpu_run      <= 1'b1;
                    state        <= S_RUN;
                end
                S_RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + CNT_W'(1);
                    if (fin_edge) begin
                        state     <= S_DRAIN;
                        cpu_run   <= 1'b0;
                        drain_cnt <= DRN_LOAD;
                    end else if (cycle_count == TO_LAST) begin
                        state   <= S_ABORT;
                        cpu_run <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state       <= S_RD;
                        mem_rd_addr <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                S_RD: begin
                    state <= S_LAT;
                end
                // Read data for mem_rd_addr arrives in this cycle.
                S_LAT: begin
                    dump_data  <= mem_rd_data;
                    dump_addr  <= mem_rd_addr;
                    dump_valid <= 1'b1;
                    state      <= S_PRES;
                end
                S_PRES: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (mem_rd_addr == LAST_ADDR) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            mem_rd_addr <= '0;
                        end else begin
                            state       <= S_RD;
                            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: random handshakes against a
// memory-image reference and run-length expectations.
module tb_cpu_run_ctrl;

    localparam int MEM_WORDS      = 512;
    localparam int ADDR_W         = 9;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int DRAIN_CYCLES   = 4;
    localparam int CNT_W          = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              cpu_finish = 1'b0;
    logic              cpu_pc_clear;
    logic              cpu_run;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic [CNT_W-1:0]  cycle_count;
    logic              done;
    logic              timeout;

    int asserts = 0;
    int fails = 0;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [ADDR_W-1:0] hs_a [$];
    logic [DATA_W-1:0] hs_d [$];
    int                valid_cnt = 0;
    int                viol = 0;
    logic              pstall = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pdata = '0;

    cpu_run_ctrl #(
        .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cpu_finish(cpu_finish),
        .cpu_pc_clear(cpu_pc_clear), .cpu_run(cpu_run),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .cycle_count(cycle_count), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory model
    always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

    // Handshake log and stall-stability monitor
    always @(posedge clk) begin
        if (!reset && dump_valid) valid_cnt <= valid_cnt + 1;
        if (!reset && pstall &&
            (!dump_valid || dump_addr !== paddr || dump_data !== pdata))
            viol <= viol + 1;
        pstall <= !reset && dump_valid && !dump_ready;
        paddr  <= dump_addr;
        pdata  <= dump_data;
        if (!reset && dump_valid && dump_ready) begin
            hs_a.push_back(dump_addr);
            hs_d.push_back(dump_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts RUN cycles; raises cpu_finish on RUN cycle fin_at.
    task automatic run_phase(input int fin_at, input int drop_at,
                             input bit poke, output int runs,
                             output int pcc);
        runs = 0;
        pcc  = 0;
        for (int c = 0; c < TIMEOUT_CYCLES + 20; c++) begin
            if (cpu_pc_clear) pcc++;
            if (cpu_run) begin
                runs++;
                if (runs == drop_at) cpu_finish = 1'b0;
                if (runs == fin_at) cpu_finish = 1'b1;
                if (poke) start = 1'($urandom % 2);
            end else if (runs > 0) begin
                break;
            end
            tick();
        end
        start = 1'b0;
    endtask

    // mode 0: ready tied high; mode 1: random ready, forced stall at 100.
    task automatic dump_phase(input int mode, output int lat,
                              output int stall_n, output int stall_bad,
                              output bit fin);
        lat       = 0;
        stall_n   = 0;
        stall_bad = 0;
        fin       = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (done) begin
                fin = 1'b1;
                break;
            end
            if (lat == 0 && dump_valid) lat = c + 1;
            if (mode == 0) begin
                dump_ready = 1'b1;
            end else if (dump_valid && dump_addr == 9'd100 && stall_n < 7) begin
                dump_ready = 1'b0;
                stall_n++;
                if (dump_data !== 32'd300) stall_bad++;
            end else begin
                dump_ready = 1'($urandom % 2);
            end
            tick();
        end
        dump_ready = 1'b0;
    endtask

    task automatic scan_dump(input int base, output int n, output int bad);
        n   = hs_a.size() - base;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (i >= MEM_WORDS || hs_a[base+i] !== ADDR_W'(i) ||
                hs_d[base+i] !== mem[i])
                bad++;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b1;
        cpu_finish = 1'b1;
        repeat (3) tick();
        asserts++;
        if ({cpu_pc_clear, cpu_run, dump_valid, done, timeout} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {cpu_pc_clear, cpu_run, dump_valid, done, timeout});
        end
        asserts++;
        if (cycle_count !== '0) begin
            fails++;
            $display("FAIL reset_count: got %0d expected 0", cycle_count);
        end
        asserts++;
        if (mem_rd_addr !== '0 || dump_addr !== '0 || dump_data !== '0) begin
            fails++;
            $display("FAIL reset_bus: rd %0d addr %0d data %0d expected 0",
                     mem_rd_addr, dump_addr, dump_data);
        end
        reset      = 1'b0;
        start      = 1'b0;
        cpu_finish = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int runs, pcc, lat, sn, sb, n, bad, base;
        bit fin;
        cpu_finish = 1'b0;
        tick();
        base = hs_a.size();
        pulse_start();
        run_phase(40, -1, 1'b0, runs, pcc);
        asserts++;
        if (runs !== 40) begin
            fails++;
            $display("FAIL basic_runs: got %0d expected 40", runs);
        end
        asserts++;
        if (pcc !== 1) begin
            fails++;
            $display("FAIL basic_pc_clear: got %0d cycles expected 1", pcc);
        end
        dump_phase(0, lat, sn, sb, fin);
        asserts++;
        if (lat !== DRAIN_CYCLES + 3) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected %0d",
                     lat, DRAIN_CYCLES + 3);
        end
        asserts++;
        if (cycle_count !== 16'd40) begin
            fails++;
            $display("FAIL basic_count: got %0d expected 40", cycle_count);
        end
        asserts++;
        if (!fin || done !== 1'b1 || dump_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: done %b valid %b expected 1 0",
                     done, dump_valid);
        end
        scan_dump(base, n, bad);
        asserts++;
        if (n !== MEM_WORDS || bad !== 0) begin
            fails++;
            $display("FAIL basic_dump: got %0d words %0d bad expected %0d 0",
                     n, bad, MEM_WORDS);
        end
    endtask

    task automatic test_finish_held();
        int runs, pcc, lat, sn, sb, n, bad, base;
        bit fin;
        cpu_finish = 1'b1;
        base = hs_a.size();
        pulse_start();
        run_phase(60, 30, 1'b1, runs, pcc);
        asserts++;
        if (runs !== 60) begin
            fails++;
            $display("FAIL held_runs: got %0d expected 60", runs);
        end
        asserts++;
        if (pcc !== 1 || cycle_count !== 16'd60) begin
            fails++;
            $display("FAIL held_count: pcc %0d count %0d expected 1 60",
                     pcc, cycle_count);
        end
        dump_phase(0, lat, sn, sb, fin);
        scan_dump(base, n, bad);
        asserts++;
        if (!fin || n !== MEM_WORDS || bad !== 0) begin
            fails++;
            $display("FAIL held_dump: got %0d words %0d bad expected %0d 0",
                     n, bad, MEM_WORDS);
        end
    endtask

    task automatic test_random_ready();
        int runs, pcc, lat, sn, sb, n, bad, base, v0;
        bit fin;
        cpu_finish = 1'b0;
        tick();
        base = hs_a.size();
        v0   = viol;
        pulse_start();
        run_phase(int'($urandom_range(10, 200)), -1, 1'b0, runs, pcc);
        dump_phase(1, lat, sn, sb, fin);
        asserts++;
        if (sn !== 7 || sb !== 0) begin
            fails++;
            $display("FAIL rand_stall100: %0d stall cycles %0d bad expected 7 0",
                     sn, sb);
        end
        asserts++;
        if (viol !== v0) begin
            fails++;
            $display("FAIL rand_stable: got %0d changes expected 0", viol - v0);
        end
        scan_dump(base, n, bad);
        asserts++;
        if (!fin || n !== MEM_WORDS || bad !== 0) begin
            fails++;
            $display("FAIL rand_dump: got %0d words %0d bad expected %0d 0",
                     n, bad, MEM_WORDS);
        end
    endtask

    task automatic test_timeout();
        int runs, pcc, v0;
        cpu_finish = 1'b0;
        tick();
        v0 = valid_cnt;
        pulse_start();
        run_phase(0, -1, 1'b0, runs, pcc);
        asserts++;
        if (runs !== TIMEOUT_CYCLES) begin
            fails++;
            $display("FAIL to_runs: got %0d expected %0d", runs, TIMEOUT_CYCLES);
        end
        asserts++;
        if (timeout !== 1'b1 || cpu_run !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL to_flags: timeout %b run %b done %b expected 1 0 0",
                     timeout, cpu_run, done);
        end
        asserts++;
        if (cycle_count !== CNT_W'(TIMEOUT_CYCLES)) begin
            fails++;
            $display("FAIL to_count: got %0d expected %0d",
                     cycle_count, TIMEOUT_CYCLES);
        end
        dump_ready = 1'b1;
        repeat (20) tick();
        dump_ready = 1'b0;
        asserts++;
        if (valid_cnt !== v0 || timeout !== 1'b1) begin
            fails++;
            $display("FAIL to_nodump: %0d valid cycles timeout %b expected 0 1",
                     valid_cnt - v0, timeout);
        end
    endtask

    task automatic test_finish_on_timeout();
        int runs, pcc, lat, sn, sb, n, bad, base;
        bit fin;
        cpu_finish = 1'b0;
        base = hs_a.size();
        pulse_start();
        run_phase(TIMEOUT_CYCLES, -1, 1'b0, runs, pcc);
        asserts++;
        if (timeout !== 1'b0 || cycle_count !== CNT_W'(TIMEOUT_CYCLES)) begin
            fails++;
            $display("FAIL fot_drain: timeout %b count %0d expected 0 %0d",
                     timeout, cycle_count, TIMEOUT_CYCLES);
        end
        dump_phase(0, lat, sn, sb, fin);
        scan_dump(base, n, bad);
        asserts++;
        if (!fin || n !== MEM_WORDS || bad !== 0) begin
            fails++;
            $display("FAIL fot_dump: got %0d words %0d bad expected %0d 0",
                     n, bad, MEM_WORDS);
        end
    endtask

    task automatic test_reset_mid_dump();
        int runs, pcc, lat, sn, sb, n, bad, base;
        bit fin, hit;
        cpu_finish = 1'b0;
        pulse_start();
        run_phase(20, -1, 1'b0, runs, pcc);
        hit = 1'b0;
        dump_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (dump_valid && dump_addr == 9'd257) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        asserts++;
        if (!hit) begin
            fails++;
            $display("FAIL mid_reach257: got no word 257 expected word 257");
        end
        reset = 1'b1;
        start = 1'b1;
        tick();
        asserts++;
        if ({cpu_pc_clear, cpu_run, dump_valid, done, timeout} !== 5'b0 ||
            cycle_count !== '0) begin
            fails++;
            $display("FAIL mid_reset_flags: got %b count %0d expected 00000 0",
                     {cpu_pc_clear, cpu_run, dump_valid, done, timeout},
                     cycle_count);
        end
        asserts++;
        if (mem_rd_addr !== '0 || dump_addr !== '0 || dump_data !== '0) begin
            fails++;
            $display("FAIL mid_reset_bus: rd %0d addr %0d data %0d expected 0",
                     mem_rd_addr, dump_addr, dump_data);
        end
        reset      = 1'b0;
        start      = 1'b0;
        dump_ready = 1'b0;
        cpu_finish = 1'b0;
        tick();
        base = hs_a.size();
        pulse_start();
        run_phase(25, -1, 1'b0, runs, pcc);
        dump_phase(0, lat, sn, sb, fin);
        scan_dump(base, n, bad);
        asserts++;
        if (!fin || n !== MEM_WORDS || bad !== 0) begin
            fails++;
            $display("FAIL mid_replay: got %0d words %0d bad expected %0d 0",
                     n, bad, MEM_WORDS);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = DATA_W'(i * 3);
        test_reset();
        test_basic();
        test_finish_held();
        test_random_ready();
        test_timeout();
        test_finish_on_timeout();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
